// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch bus, data bus and single-beat memory port that the arbiter joins.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_bus_arbiter_if;

  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;

  logic        mem_valid;
  logic        mem_is_write;
  logic [63:0] mem_addr;
  logic [2:0]  mem_size;
  logic [7:0]  mem_strobe;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  mem_ready, mem_rdata,
    output i_data_ok, i_data,
    output d_data_ok, d_rdata,
    output mem_valid, mem_is_write, mem_addr, mem_size, mem_strobe, mem_wdata
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    output mem_ready, mem_rdata,
    input  i_data_ok, i_data,
    input  d_data_ok, d_rdata,
    input  mem_valid, mem_is_write, mem_addr, mem_size, mem_strobe, mem_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises fetch and data requests onto one single-beat memory port.
// Data bus has priority; fetch is guaranteed a grant after MAX_STREAK data grants.
module mem_bus_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int StreakW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_e;

  arbState_e          state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;

  logic               memValid_q, memValid_d;
  logic               memIsWrite_q, memIsWrite_d;
  logic [63:0]        memAddr_q, memAddr_d;
  logic [2:0]         memSize_q, memSize_d;
  logic [7:0]         memStrobe_q, memStrobe_d;
  logic [63:0]        memWdata_q, memWdata_d;

  logic               iDataOk_q, iDataOk_d;
  logic               dDataOk_q, dDataOk_d;
  logic [31:0]        iData_q, iData_d;
  logic [63:0]        dRdata_q, dRdata_d;

  logic               grantD;

  // Fetch only overrides a pending data request once the data streak is exhausted.
  assign grantD = bus.d_valid && !(bus.i_valid && (streak_q == MaxStreak));

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    memValid_d   = memValid_q;
    memIsWrite_d = memIsWrite_q;
    memAddr_d    = memAddr_q;
    memSize_d    = memSize_q;
    memStrobe_d  = memStrobe_q;
    memWdata_d   = memWdata_q;
    iDataOk_d    = 1'b0;
    dDataOk_d    = 1'b0;
    iData_d      = iData_q;
    dRdata_d     = dRdata_q;

    case (state_q)
      IDLE: begin
        if (grantD) begin
          state_d      = BUSY_D;
          memValid_d   = 1'b1;
          memIsWrite_d = (bus.d_strobe != 8'd0);
          memAddr_d    = bus.d_addr;
          memSize_d    = bus.d_size;
          memStrobe_d  = bus.d_strobe;
          memWdata_d   = bus.d_wdata;
          if (!bus.i_valid) begin
            streak_d = '0;
          end else if (streak_q != MaxStreak) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (bus.i_valid) begin
          state_d      = BUSY_I;
          memValid_d   = 1'b1;
          memIsWrite_d = 1'b0;
          memAddr_d    = bus.i_addr;
          memSize_d    = 3'd2;
          memStrobe_d  = 8'd0;
          memWdata_d   = 64'd0;
          streak_d     = '0;
        end
      end

      // The pulse is registered on entry to RESP so it lines up with that state.
      BUSY_I: begin
        if (bus.mem_ready) begin
          state_d    = RESP;
          memValid_d = 1'b0;
          iDataOk_d  = 1'b1;
          iData_d    = memAddr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        end
      end

      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d    = RESP;
          memValid_d = 1'b0;
          dDataOk_d  = 1'b1;
          dRdata_d   = bus.mem_rdata;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        memValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      memValid_q   <= 1'b0;
      memIsWrite_q <= 1'b0;
      memAddr_q    <= 64'd0;
      memSize_q    <= 3'd0;
      memStrobe_q  <= 8'd0;
      memWdata_q   <= 64'd0;
      iDataOk_q    <= 1'b0;
      dDataOk_q    <= 1'b0;
      iData_q      <= 32'd0;
      dRdata_q     <= 64'd0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      memValid_q   <= memValid_d;
      memIsWrite_q <= memIsWrite_d;
      memAddr_q    <= memAddr_d;
      memSize_q    <= memSize_d;
      memStrobe_q  <= memStrobe_d;
      memWdata_q   <= memWdata_d;
      iDataOk_q    <= iDataOk_d;
      dDataOk_q    <= dDataOk_d;
      iData_q      <= iData_d;
      dRdata_q     <= dRdata_d;
    end
  end

  assign bus.mem_valid    = memValid_q;
  assign bus.mem_is_write = memIsWrite_q;
  assign bus.mem_addr     = memAddr_q;
  assign bus.mem_size     = memSize_q;
  assign bus.mem_strobe   = memStrobe_q;
  assign bus.mem_wdata    = memWdata_q;
  assign bus.i_data_ok    = iDataOk_q;
  assign bus.i_data       = iData_q;
  assign bus.d_data_ok    = dDataOk_q;
  assign bus.d_rdata      = dRdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch word select, priority, streak guard,
// writes, long stalls and asynchronous reset abort.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] dAddr;
  logic [63:0] iAddr;
  logic        expI;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] ia,
                               input logic dv, input logic [63:0] da, input logic [2:0] dsz,
                               input logic [7:0] dstb, input logic [63:0] dwd,
                               input logic rdy, input logic [63:0] rdata);
    bus.i_valid   = iv;
    bus.i_addr    = ia;
    bus.d_valid   = dv;
    bus.d_addr    = da;
    bus.d_size    = dsz;
    bus.d_strobe  = dstb;
    bus.d_wdata   = dwd;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One fetch with mem_ready arriving in the second busy cycle.
  task automatic runFetch(input logic [63:0] addr, input logic [63:0] rdata,
                          input logic [31:0] expWord, input string tag);
    applyStimulus(1'b1, addr, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0, 1'b0, 64'd0);
    tick;
    checkOutput({tag, "_c1_valid"}, 64'(bus.mem_valid), 64'd1);
    checkOutput({tag, "_c1_addr"}, bus.mem_addr, addr);
    checkOutput({tag, "_c1_size"}, 64'(bus.mem_size), 64'd2);
    checkOutput({tag, "_c1_wr"}, 64'({bus.mem_is_write, bus.mem_strobe}), 64'd0);
    checkOutput({tag, "_c1_ok"}, 64'(bus.i_data_ok), 64'd0);
    tick;
    checkOutput({tag, "_c2_valid"}, 64'(bus.mem_valid), 64'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    tick;
    checkOutput({tag, "_c3_ok"}, 64'({bus.i_data_ok, bus.d_data_ok}), 64'b10);
    checkOutput({tag, "_c3_valid"}, 64'(bus.mem_valid), 64'd0);
    checkOutput({tag, "_c3_data"}, 64'(bus.i_data), 64'(expWord));
    bus.i_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;
    checkOutput({tag, "_c4_ok"}, 64'(bus.i_data_ok), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0, 1'b0, 64'd0);
    tick;
    tick;
    checkOutput("rst_valid", 64'(bus.mem_valid), 64'd0);
    checkOutput("rst_wr", 64'(bus.mem_is_write), 64'd0);
    checkOutput("rst_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'd0);
    checkOutput("rst_addr", bus.mem_addr, 64'd0);
    checkOutput("rst_idata", 64'(bus.i_data), 64'd0);
    checkOutput("rst_drdata", bus.d_rdata, 64'd0);
    reset = 1'b1;

    runFetch(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222, "fetchHi");
    runFetch(64'h8000_0000, 64'h1111_2222_3333_4444, 32'h3333_4444, "fetchLo");

    // Simultaneous requests: data first, fetch after, no overlap.
    applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 3'd3, 8'd0, 64'd0,
                  1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    tick;
    checkOutput("both_c1_valid", 64'(bus.mem_valid), 64'd1);
    checkOutput("both_c1_addr", bus.mem_addr, 64'h8000_0100);
    checkOutput("both_c1_size", 64'(bus.mem_size), 64'd3);
    checkOutput("both_c1_wr", 64'(bus.mem_is_write), 64'd0);
    tick;
    checkOutput("both_c2_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b01);
    checkOutput("both_c2_valid", 64'(bus.mem_valid), 64'd0);
    checkOutput("both_c2_rdata", bus.d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    bus.d_valid = 1'b0;
    tick;
    checkOutput("both_c3_valid", 64'(bus.mem_valid), 64'd0);
    checkOutput("both_c3_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b00);
    tick;
    checkOutput("both_c4_valid", 64'(bus.mem_valid), 64'd1);
    checkOutput("both_c4_addr", bus.mem_addr, 64'h8000_0010);
    tick;
    checkOutput("both_c5_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b10);
    checkOutput("both_c5_idata", 64'(bus.i_data), 64'hCCCC_DDDD);
    bus.i_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;

    // Streak guard: both held, fetch wins every fifth grant.
    dAddr = 64'h8000_0200;
    iAddr = 64'h8000_0020;
    applyStimulus(1'b1, iAddr, 1'b1, dAddr, 3'd3, 8'd0, 64'd0, 1'b1, 64'h0000_0000_1234_5678);
    for (int t = 0; t < 10; t++) begin
      expI = ((t % 5) == 4);
      tick;
      checkOutput($sformatf("streak%0d_addr", t), bus.mem_addr, expI ? iAddr : dAddr);
      tick;
      checkOutput($sformatf("streak%0d_ok", t), 64'({bus.i_data_ok, bus.d_data_ok}),
                  expI ? 64'b10 : 64'b01);
      if (!expI) begin
        dAddr      = dAddr + 64'd8;
        bus.d_addr = dAddr;
      end
      tick;
    end
    bus.i_valid   = 1'b0;
    bus.d_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;

    // Data write.
    applyStimulus(1'b0, 64'd0, 1'b1, 64'h8000_0008, 3'd2, 8'hF0, 64'hDEAD_BEEF_0000_0000,
                  1'b0, 64'd0);
    tick;
    checkOutput("wr_valid", 64'(bus.mem_valid), 64'd1);
    checkOutput("wr_iswrite", 64'(bus.mem_is_write), 64'd1);
    checkOutput("wr_strobe", 64'(bus.mem_strobe), 64'hF0);
    checkOutput("wr_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_0000);
    checkOutput("wr_addr", bus.mem_addr, 64'h8000_0008);
    checkOutput("wr_size", 64'(bus.mem_size), 64'd2);
    bus.mem_ready = 1'b1;
    tick;
    checkOutput("wr_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b01);
    bus.d_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;
    checkOutput("wr_okPulse", 64'(bus.d_data_ok), 64'd0);
    checkOutput("wr_idle", 64'(bus.mem_valid), 64'd0);

    // Twenty-cycle stall in BUSY_D.
    applyStimulus(1'b0, 64'd0, 1'b1, 64'h8000_0300, 3'd1, 8'd0, 64'd0, 1'b0, 64'd0);
    tick;
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("stall%0d_flags", c),
                  64'({bus.mem_valid, bus.i_data_ok, bus.d_data_ok}), 64'b100);
      checkOutput($sformatf("stall%0d_addr", c), bus.mem_addr, 64'h8000_0300);
      checkOutput($sformatf("stall%0d_ctl", c),
                  64'({bus.mem_is_write, bus.mem_size, bus.mem_strobe}), 64'h100);
      tick;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick;
    checkOutput("stall_ok", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b01);
    checkOutput("stall_rdata", bus.d_rdata, 64'h0123_4567_89AB_CDEF);
    bus.d_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;

    // Asynchronous reset in the middle of a data transaction.
    applyStimulus(1'b1, 64'h8000_0044, 1'b1, 64'h8000_0400, 3'd3, 8'd0, 64'd0, 1'b0, 64'd0);
    tick;
    checkOutput("abort_busy", 64'(bus.mem_valid), 64'd1);
    checkOutput("abort_busyAddr", bus.mem_addr, 64'h8000_0400);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", 64'(bus.mem_valid), 64'd0);
    checkOutput("abort_addr", bus.mem_addr, 64'd0);
    checkOutput("abort_size", 64'(bus.mem_size), 64'd0);
    checkOutput("abort_idata", 64'(bus.i_data), 64'd0);
    checkOutput("abort_drdata", bus.d_rdata, 64'd0);
    bus.d_valid = 1'b0;
    tick;
    checkOutput("abort_held", 64'({bus.mem_valid, bus.i_data_ok, bus.d_data_ok}), 64'd0);
    reset = 1'b1;
    tick;
    checkOutput("abort_iValid", 64'(bus.mem_valid), 64'd1);
    checkOutput("abort_iAddr", bus.mem_addr, 64'h8000_0044);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'hFEED_FACE_0000_0000;
    tick;
    checkOutput("abort_iOk", 64'({bus.i_data_ok, bus.d_data_ok}), 64'b10);
    checkOutput("abort_iData", 64'(bus.i_data), 64'hFEED_FACE);
    bus.i_valid   = 1'b0;
    bus.mem_ready = 1'b0;
    tick;
    checkOutput("abort_quiet", 64'({bus.i_data_ok, bus.d_data_ok}), 64'd0);
    tick;
    checkOutput("abort_quiet2", 64'({bus.mem_valid, bus.d_data_ok}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
